// File: rtl/rr_lock_arb.sv
// Round-robin arbiter with a registered one-hot grant and per-requester transfer locking.
// A requester keeps the grant until its last beat is accepted, it withdraws its request,
// or (optionally) a lock timeout fires. After any of these the grant rotates to the next
// requester with no idle cycle in between.
// Optional feature: define RR_ARB_TIMEOUT_EN to enable the forced-release lock timeout.
module rr_lock_arb #(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = (REQCNT > 1) ? $clog2(REQCNT) : 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [REQCNT-1:0]   req_i,
  input  logic [REQCNT-1:0]   last_i,
  input  logic                ready_i,
  output logic [REQCNT-1:0]   gnt_o,
  output logic [REQWIDTH-1:0] gnt_num_o,
  output logic                gnt_val_o,
  output logic                timeout_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [REQCNT-1:0]   gnt_r, gnt_s;
  logic [REQWIDTH-1:0] gnt_num_r, gnt_num_s;
  logic                gnt_val_r, gnt_val_s;
  logic [REQWIDTH-1:0] ptr_r, ptr_s;
  logic                timeout_r, timeout_s;
  logic [REQWIDTH-1:0] ptr_next_s;
  logic [REQWIDTH:0]   pick_s;
  logic                beat_s, rel_last_s, rel_abort_s, rel_to_s, load_s;

  // First requester at or after ptr, wrapping past REQCNT-1; MSB of the result flags a winner.
  function automatic logic [REQWIDTH:0] rr_pick(input logic [REQCNT-1:0] req,
                                                input logic [REQWIDTH-1:0] ptr);
    logic                found;
    logic [REQWIDTH-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int j = REQCNT - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) begin
        found = 1'b1;
        win   = REQWIDTH'(j);
      end
    end
    if (!found) begin
      for (int j = REQCNT - 1; j >= 0; j--) begin
        if (req[j]) begin
          found = 1'b1;
          win   = REQWIDTH'(j);
        end
      end
    end
    return {found, win};
  endfunction

  // Expand a requester index into a one-hot grant vector.
  function automatic logic [REQCNT-1:0] onehot(input logic [REQWIDTH-1:0] idx);
    logic [REQCNT-1:0] v;
    for (int j = 0; j < REQCNT; j++) begin
      v[j] = (j == int'(idx));
    end
    return v;
  endfunction

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  logic [CNTW-1:0] cnt_r;

  // Lock-age counter: restarts on each grant load or accepted beat, ages while locked.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= '0;
    end else if (load_s || beat_s) begin
      cnt_r <= '0;
    end else if (state_r == LOCK) begin
      cnt_r <= cnt_r + CNTW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A lock that reaches its limit without a beat is forced to release.
  always_comb begin
    rel_to_s = (state_r == LOCK) && !beat_s && (cnt_r == CNTW'(TIMEOUT - 1));
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT < 2);

  // Without the timeout feature a lock is never forced open.
  always_comb begin
    rel_to_s = 1'b0;
  end
`endif

  // Release causes of the current holder; other requesters' last/req are irrelevant here.
  always_comb begin
    beat_s      = gnt_val_r & ready_i;
    rel_last_s  = beat_s & last_i[gnt_num_r];
    rel_abort_s = gnt_val_r & ~req_i[gnt_num_r];
    ptr_next_s  = (gnt_num_r == REQWIDTH'(REQCNT - 1)) ? '0 : (gnt_num_r + REQWIDTH'(1));
  end

  // Next-state logic: arbitrate from IDLE, hold or rotate the lock on release.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    gnt_num_s = gnt_num_r;
    gnt_val_s = gnt_val_r;
    ptr_s     = ptr_r;
    timeout_s = 1'b0;
    load_s    = 1'b0;
    pick_s    = '0;
    case (state_r)
      IDLE: begin
        pick_s = rr_pick(req_i, ptr_r);
        if (pick_s[REQWIDTH]) begin
          load_s    = 1'b1;
          state_s   = LOCK;
          gnt_s     = onehot(pick_s[REQWIDTH-1:0]);
          gnt_num_s = pick_s[REQWIDTH-1:0];
          gnt_val_s = 1'b1;
        end else begin
          state_s   = IDLE;
          gnt_s     = '0;
          gnt_num_s = '0;
          gnt_val_s = 1'b0;
        end
      end
      LOCK: begin
        if (rel_last_s || rel_abort_s || rel_to_s) begin
          // An aborting holder has req low, so it drops out of the search naturally.
          ptr_s     = ptr_next_s;
          timeout_s = rel_to_s & ~rel_last_s;
          pick_s    = rr_pick(req_i, ptr_next_s);
          if (pick_s[REQWIDTH]) begin
            load_s    = 1'b1;
            state_s   = LOCK;
            gnt_s     = onehot(pick_s[REQWIDTH-1:0]);
            gnt_num_s = pick_s[REQWIDTH-1:0];
            gnt_val_s = 1'b1;
          end else begin
            state_s   = IDLE;
            gnt_s     = '0;
            gnt_num_s = '0;
            gnt_val_s = 1'b0;
          end
        end else begin
          state_s = LOCK;
        end
      end
      default: begin
        state_s   = IDLE;
        gnt_s     = '0;
        gnt_num_s = '0;
        gnt_val_s = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= IDLE;
      gnt_r     <= '0;
      gnt_num_r <= '0;
      gnt_val_r <= 1'b0;
      ptr_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      gnt_num_r <= gnt_num_s;
      gnt_val_r <= gnt_val_s;
      ptr_r     <= ptr_s;
      timeout_r <= timeout_s;
    end
  end

  assign gnt_o     = gnt_r;
  assign gnt_num_o = gnt_num_r;
  assign gnt_val_o = gnt_val_r;
  assign timeout_o = timeout_r;

endmodule

// File: tb/tb_rr_lock_arb.sv
// Bench for rr_lock_arb (default build, REQCNT=5): directed scenarios plus randomized
// traffic checked against a queue-free behavioural round-robin model.
module tb_rr_lock_arb;
  localparam int N = 5;

  logic         clk_i;
  logic         rst_n_i;
  logic [N-1:0] req_i;
  logic [N-1:0] last_i;
  logic         ready_i;
  logic [N-1:0] gnt_o;
  logic [2:0]   gnt_num_o;
  logic         gnt_val_o;
  logic         timeout_o;

  int tests_run;
  int tests_failed;
  int m_ptr;
  int m_gnt;

  rr_lock_arb #(.REQCNT(N), .REQWIDTH(3), .TIMEOUT(16)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .req_i     (req_i),
    .last_i    (last_i),
    .ready_i   (ready_i),
    .gnt_o     (gnt_o),
    .gnt_num_o (gnt_num_o),
    .gnt_val_o (gnt_val_o),
    .timeout_o (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Model: first requesting index scanning upward from ptr modulo N, -1 if none.
  function automatic int m_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_vec(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] exp_num(input int g);
    return (g >= 0) ? 3'(g) : 3'd0;
  endfunction

  task automatic model_update();
    if (m_gnt < 0) begin
      m_gnt = m_pick(req_i, m_ptr);
    end else if ((ready_i && last_i[m_gnt]) || !req_i[m_gnt]) begin
      m_ptr = (m_gnt + 1) % N;
      m_gnt = m_pick(req_i, m_ptr);
    end
  endtask

  // Apply inputs for one clock, advance the model, land on the next falling edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
    req_i   = r;
    last_i  = l;
    ready_i = rdy;
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    req_i = '0; last_i = '0; ready_i = 1'b0;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    m_ptr = 0;
    m_gnt = -1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    req_i = 5'h1F; last_i = '0; ready_i = 1'b0;
    rst_n_i = 1'b0;
    #3;
    tests_run++;
    if (gnt_o !== 5'b00000 || gnt_val_o !== 1'b0 || gnt_num_o !== 3'd0 || timeout_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs gnt=%b num=%0d val=%b to=%b, required all 0", gnt_o, gnt_num_o, gnt_val_o, timeout_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    tests_run++;
    if (gnt_o !== 5'b00000 || gnt_val_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held gnt=%b val=%b, required 0", gnt_o, gnt_val_o);
    end
    rst_n_i = 1'b1;
    m_ptr = 0;
    m_gnt = -1;
    step(5'h1F, 5'h00, 1'b0);
    tests_run++;
    if (gnt_num_o !== 3'd0 || gnt_o !== 5'b00001 || gnt_val_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_grant num=%0d gnt=%b val=%b, required 0 00001 1", gnt_num_o, gnt_o, gnt_val_o);
    end
  endtask

  task automatic test_rotation();
    int rot_exp[6] = '{1, 2, 3, 4, 0, 1};
    for (int k = 0; k < 6; k++) begin
      step(5'h1F, 5'h1F, 1'b1);
      tests_run++;
      if (gnt_num_o !== 3'(rot_exp[k]) || gnt_val_o !== 1'b1 || gnt_o !== exp_vec(rot_exp[k])) begin
        tests_failed++;
        $display("FAIL rotation[%0d] num=%0d gnt=%b val=%b, required %0d", k, gnt_num_o, gnt_o, gnt_val_o, rot_exp[k]);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(5'b00110, 5'b00000, 1'b1);
      tests_run++;
      if (gnt_num_o !== 3'd1 || gnt_o !== 5'b00010) begin
        tests_failed++;
        $display("FAIL lock_hold[%0d] num=%0d gnt=%b, required 1", k, gnt_num_o, gnt_o);
      end
    end
    step(5'b00110, 5'b00010, 1'b1);
    tests_run++;
    if (gnt_num_o !== 3'd2 || gnt_o !== 5'b00100) begin
      tests_failed++;
      $display("FAIL lock_release num=%0d gnt=%b, required 2", gnt_num_o, gnt_o);
    end
    // Releasing 2 moves ptr to 3; search 3,4,0,1 lands on 1.
    step(5'b00110, 5'b00100, 1'b1);
    tests_run++;
    if (gnt_num_o !== 3'd1) begin
      tests_failed++;
      $display("FAIL lock_ptr_after num=%0d, required 1", gnt_num_o);
    end
  endtask

  task automatic test_abort_wrap();
    do_reset();
    step(5'b10000, 5'b00000, 1'b0);
    tests_run++;
    if (gnt_num_o !== 3'd4) begin
      tests_failed++;
      $display("FAIL abort_setup num=%0d, required 4", gnt_num_o);
    end
    step(5'b00001, 5'b00000, 1'b0);
    tests_run++;
    if (gnt_num_o !== 3'd0 || gnt_o !== 5'b00001 || gnt_val_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_regrant num=%0d gnt=%b, required 0 00001", gnt_num_o, gnt_o);
    end
    do_reset();
    step(5'b10000, 5'b00000, 1'b0);
    step(5'b00000, 5'b00000, 1'b0);
    tests_run++;
    if (gnt_val_o !== 1'b0 || gnt_o !== 5'b00000 || gnt_num_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL abort_idle val=%b gnt=%b num=%0d, required cleared", gnt_val_o, gnt_o, gnt_num_o);
    end
    step(5'b10001, 5'b00000, 1'b0);
    tests_run++;
    if (gnt_num_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL abort_wrap_ptr num=%0d, required 0", gnt_num_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(5'b00001, 5'h1F, 1'b1);
    step(5'b01000, 5'h1F, 1'b1);
    tests_run++;
    if (gnt_num_o !== 3'd3) begin
      tests_failed++;
      $display("FAIL async_setup num=%0d, required 3", gnt_num_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    tests_run++;
    if (gnt_o !== 5'b00000 || gnt_val_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_drop gnt=%b val=%b, required 0", gnt_o, gnt_val_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    m_ptr = 0;
    m_gnt = -1;
    step(5'b01001, 5'b00000, 1'b0);
    tests_run++;
    if (gnt_num_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_ptr_restart num=%0d, required 0", gnt_num_o);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 31));
      step(r, N'($urandom_range(0, 31)) & N'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      tests_run++;
      if (gnt_o !== exp_vec(m_gnt) || gnt_num_o !== exp_num(m_gnt) || gnt_val_o !== (m_gnt >= 0)
          || timeout_o !== 1'b0 || $countones(gnt_o) > 1) begin
        tests_failed++;
        $display("FAIL random[%0d] gnt=%b num=%0d val=%b to=%b, required gnt=%b num=%0d",
                 c, gnt_o, gnt_num_o, gnt_val_o, timeout_o, exp_vec(m_gnt), exp_num(m_gnt));
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n_i = 1'b0;
    req_i = '0; last_i = '0; ready_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_rotation();
    test_lock();
    test_abort_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
